regf_arbiter: RTL and testbench
===============================

Name: regf_arbiter

Overview:
Shares the single access port of the 16-entry picoVersat register file between three requesters: the host parallel interface (testbench/debug dump), the picoVersat core, and the PS2 scan-code receiver. The host has fixed top priority. Core and PS2 alternate round-robin. A wait counter stops the host from starving the other two during long dumps. The block sits in xtop between the requesters and regf.

Parameters:
ADDR_W, 4, register file address width (matches REGF_ADDR_W)
DATA_W, 32, data width (matches DATA_W)
MAX_WAIT, 8, consecutive blocked cycles after which a core/PS2 request overrides the host (range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
h_req / c_req / p_req  in  1  access request from host / core / PS2
h_we / c_we / p_we  in  1  1 = write, 0 = read
h_addr / c_addr / p_addr  in  ADDR_W  target register
h_wdata / c_wdata / p_wdata  in  DATA_W  write data
h_lock  in  1  host lock; while high, core and PS2 are blocked (the starvation override still applies)
h_gnt / c_gnt / p_gnt  out  1  access accepted this cycle
h_rdata / c_rdata / p_rdata  out  DATA_W  captured read data
h_rvalid / c_rvalid / p_rvalid  out  1  one-cycle pulse: rdata updated
rf_we  out  1  register file write enable
rf_addr  out  ADDR_W  register file address
rf_wdata  out  DATA_W  register file write data
rf_rdata  in  DATA_W  register file read data (combinational from rf_addr)
starve_ovr  out  1  high in the cycle a starvation override grant is issued

Behaviour:
- Reset values (async, immediate): all *_gnt 0, all *_rvalid 0, all *_rdata 0, starve_ovr 0, rr_last = PS2 (so the core wins the first tie), wait_c = wait_p = 0. rf_we is 0 during reset.
- Grant decision is combinational on the current requests and registered state. At most one of the three gnt signals is high per cycle. One access per cycle; no idle cycle is required between grants.
- Priority in each cycle:
  - 1) Override: if wait_c >= MAX_WAIT or wait_p >= MAX_WAIT, grant the one whose counter is at or above MAX_WAIT. If both are, use round-robin. Assert starve_ovr.
  - 2) Otherwise, if h_req, grant the host.
  - 3) Otherwise, if h_lock, grant nobody.
  - 4) Otherwise, round-robin between c_req and p_req. The requester that is not rr_last wins a tie; a sole requester always wins.
- rf_* are driven combinationally from the granted requester's we/addr/wdata. rf_we = granted requester's we. With no grant, rf_we = 0 and rf_addr/rf_wdata = 0.
- Read grant in cycle t: at the clock edge ending t, rf_rdata is captured into that requester's rdata, and its rvalid is 1 for cycle t+1 only. A write grant produces no rvalid.
- rdata holds its value until the next read completes for that requester.
- Requesters hold req/we/addr/wdata stable until they see gnt. They may drop req in the cycle after gnt, or keep it high for back-to-back accesses.
- rr_last updates to core or PS2 on each core/PS2 grant, including override grants. Host grants leave it unchanged.
- wait_c (and likewise wait_p) behaviour:
  - Increments (saturating at 255) each cycle that c_req=1 and c_gnt=0.
  - Clears to 0 on c_gnt or when c_req=0.
- Simultaneous read and write to the same address by different requesters in consecutive cycles: the order follows the grant order; the arbiter adds no forwarding.
- Reset asserted mid-access: the pending rvalid is dropped, counters clear, and no write is issued during reset.
- The arbiter adds no latency: a write lands at the edge ending its grant cycle, and read data is usable in cycle t+1.

Test Plan:
- Reset, then core only: c_req=1, c_we=1, c_addr=3, c_wdata=0x0000_00AB -> c_gnt=1 in the same cycle, rf_we=1, rf_addr=3. A following core read of addr 3 gives c_rvalid in the next cycle with c_rdata=0xAB.
- Core and PS2 both request continuously (reads of addr 1 and 2) -> grants alternate C,P,C,P starting with C. Each rvalid lags its gnt by exactly 1 cycle.
- Host and core request in the same cycle -> h_gnt=1, c_gnt=0. The core is granted in the first cycle after the host drops h_req.
- Host dump: h_req held for 20 cycles while c_req=1, MAX_WAIT=8 -> c_gnt=1 with starve_ovr=1 in the cycle wait_c reaches 8. The host resumes next cycle, and the core's next override comes no earlier than 8 blocked cycles later.
- h_lock=1 with h_req=0 and p_req=1 -> no grant and rf_we=0 until the override fires at wait_p=8. After h_lock drops, p_gnt follows immediately.
- Assert rst in the cycle after a PS2 read grant -> p_rvalid stays 0, all counters read 0, and the first grant after release goes to the core on a core/PS2 tie.

Source files
------------

// File: rtl/regf_arbiter.sv
// Three-way arbiter for the single access port of the picoVersat register file.
// Host has fixed priority, core/PS2 alternate, and a wait counter keeps long host dumps from starving them.
module regf_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,

    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_rvalid,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,

    output logic              starve_ovr
);

    // Handshake: *_req is the valid; the requester holds req/we/addr/wdata
    // stable until *_gnt (the ready) is seen high in the same cycle. A grant
    // completes the access at the closing edge; reads answer with *_rvalid
    // for exactly one cycle afterwards. No backpressure on rvalid.

    typedef enum logic {
        RR_CORE = 1'b0,
        RR_PS2  = 1'b1
    } rr_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [7:0] WAIT_SAT   = 8'hFF;

    rr_t        rr_q;
    rr_t        rr_d;
    logic [7:0] wait_c_q;
    logic [7:0] wait_c_d;
    logic [7:0] wait_p_q;
    logic [7:0] wait_p_d;
    logic       ovr_c;
    logic       ovr_p;

    // Grant decision; everything is masked while rst is high so no write can leak out.
    always_comb begin
        h_gnt      = 1'b0;
        c_gnt      = 1'b0;
        p_gnt      = 1'b0;
        starve_ovr = 1'b0;
        ovr_c      = c_req && (wait_c_q >= WAIT_LIMIT);
        ovr_p      = p_req && (wait_p_q >= WAIT_LIMIT);
        if (!rst) begin
            if (ovr_c || ovr_p) begin
                starve_ovr = 1'b1;
                if (ovr_c && ovr_p) begin
                    if (rr_q == RR_PS2) c_gnt = 1'b1;
                    else                p_gnt = 1'b1;
                end else if (ovr_c) begin
                    c_gnt = 1'b1;
                end else begin
                    p_gnt = 1'b1;
                end
            end else if (h_req) begin
                h_gnt = 1'b1;
            end else if (!h_lock) begin
                if (c_req && (!p_req || rr_q == RR_PS2)) c_gnt = 1'b1;
                else if (p_req)                          p_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        if (h_gnt) begin
            rf_we    = h_we;
            rf_addr  = h_addr;
            rf_wdata = h_wdata;
        end else if (c_gnt) begin
            rf_we    = c_we;
            rf_addr  = c_addr;
            rf_wdata = c_wdata;
        end else if (p_gnt) begin
            rf_we    = p_we;
            rf_addr  = p_addr;
            rf_wdata = p_wdata;
        end
    end

    // Round-robin pointer and starvation counters: next-state logic.
    always_comb begin
        rr_d = rr_q;
        if (c_gnt)      rr_d = RR_CORE;
        else if (p_gnt) rr_d = RR_PS2;

        wait_c_d = 8'd0;
        if (c_req && !c_gnt) begin
            wait_c_d = (wait_c_q == WAIT_SAT) ? wait_c_q : wait_c_q + 8'd1;
        end

        wait_p_d = 8'd0;
        if (p_req && !p_gnt) begin
            wait_p_d = (wait_p_q == WAIT_SAT) ? wait_p_q : wait_p_q + 8'd1;
        end
    end

    // Reset leaves PS2 as last winner so the core takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q     <= RR_PS2;
            wait_c_q <= 8'd0;
            wait_p_q <= 8'd0;
        end else begin
            rr_q     <= rr_d;
            wait_c_q <= wait_c_d;
            wait_p_q <= wait_p_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_rvalid <= 1'b0;
            c_rvalid <= 1'b0;
            p_rvalid <= 1'b0;
            h_rdata  <= '0;
            c_rdata  <= '0;
            p_rdata  <= '0;
        end else begin
            h_rvalid <= h_gnt && !h_we;
            c_rvalid <= c_gnt && !c_we;
            p_rvalid <= p_gnt && !p_we;
            if (h_gnt && !h_we) h_rdata <= rf_rdata;
            if (c_gnt && !c_we) c_rdata <= rf_rdata;
            if (p_gnt && !p_we) p_rdata <= rf_rdata;
        end
    end

endmodule

// File: tb/tb_regf_arbiter.sv
// Bench for regf_arbiter: scenario tasks check grants inline, a scoreboard
// pairs every expected read with the following rvalid/rdata.
module tb_regf_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst;
  logic h_req, h_we, h_lock, c_req, c_we, p_req, p_we;
  logic [ADDR_W-1:0] h_addr, c_addr, p_addr;
  logic [DATA_W-1:0] h_wdata, c_wdata, p_wdata;
  logic h_gnt, c_gnt, p_gnt, h_rvalid, c_rvalid, p_rvalid;
  logic [DATA_W-1:0] h_rdata, c_rdata, p_rdata;
  logic rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata;
  logic starve_ovr;

  regf_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .starve_ovr(starve_ovr)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Register file stand-in (rf_mem) and the bench's own expectation of its contents (model).
  logic [DATA_W-1:0] rf_mem[16];
  logic [DATA_W-1:0] model[16];
  always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_addr];

  int total = 0;
  int bad = 0;

  // Scoreboard
  logic [DATA_W-1:0] exp_q_h[$];
  logic [DATA_W-1:0] exp_q_c[$];
  logic [DATA_W-1:0] exp_q_p[$];
  logic exp_rv_h = 1'b0;
  logic exp_rv_c = 1'b0;
  logic exp_rv_p = 1'b0;
  logic [DATA_W-1:0] sb_v;

  task automatic push_read(input int who, input logic [ADDR_W-1:0] a);
    case (who)
      0: begin exp_q_h.push_back(model[a]); exp_rv_h = 1'b1; end
      1: begin exp_q_c.push_back(model[a]); exp_rv_c = 1'b1; end
      default: begin exp_q_p.push_back(model[a]); exp_rv_p = 1'b1; end
    endcase
  endtask

  always begin
    @(posedge clk);
    #2;
    total++;
    if (h_rvalid !== exp_rv_h) begin bad++; $display("FAIL sb_h_rvalid got=%b exp=%b t=%0t", h_rvalid, exp_rv_h, $time); end
    if (exp_rv_h) begin
      sb_v = exp_q_h.pop_front(); total++;
      if (h_rdata !== sb_v) begin bad++; $display("FAIL sb_h_rdata got=%h exp=%h t=%0t", h_rdata, sb_v, $time); end
    end
    total++;
    if (c_rvalid !== exp_rv_c) begin bad++; $display("FAIL sb_c_rvalid got=%b exp=%b t=%0t", c_rvalid, exp_rv_c, $time); end
    if (exp_rv_c) begin
      sb_v = exp_q_c.pop_front(); total++;
      if (c_rdata !== sb_v) begin bad++; $display("FAIL sb_c_rdata got=%h exp=%h t=%0t", c_rdata, sb_v, $time); end
    end
    total++;
    if (p_rvalid !== exp_rv_p) begin bad++; $display("FAIL sb_p_rvalid got=%b exp=%b t=%0t", p_rvalid, exp_rv_p, $time); end
    if (exp_rv_p) begin
      sb_v = exp_q_p.pop_front(); total++;
      if (p_rdata !== sb_v) begin bad++; $display("FAIL sb_p_rdata got=%h exp=%h t=%0t", p_rdata, sb_v, $time); end
    end
    exp_rv_h = 1'b0;
    exp_rv_c = 1'b0;
    exp_rv_p = 1'b0;
  end

  // Driver tasks: inputs change only just after a rising edge, outputs are sampled at the falling edge.
  task automatic idle();
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    c_req = 1; c_we = 1; c_addr = 4'd12; c_wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", {h_gnt, c_gnt, p_gnt}); end
    total++;
    if ({h_rvalid, c_rvalid, p_rvalid, starve_ovr, rf_we} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {h_rvalid, c_rvalid, p_rvalid, starve_ovr, rf_we});
    end
    total++;
    if ({h_rdata, c_rdata, p_rdata} !== '0) begin bad++; $display("FAIL reset_rdata got=%h/%h/%h exp=0", h_rdata, c_rdata, p_rdata); end
    total++;
    if ({rf_addr, rf_wdata} !== '0) begin bad++; $display("FAIL reset_rf_bus got=%h/%h exp=0", rf_addr, rf_wdata); end
    next_cycle();
    rst = 0;
    idle();
  endtask

  task automatic test_core_only();
    next_cycle();
    c_req = 1; c_we = 1; c_addr = 4'd3; c_wdata = 32'h0000_00AB;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b010) begin bad++; $display("FAIL core_wr_gnt got=%b exp=010", {h_gnt, c_gnt, p_gnt}); end
    total++;
    if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 4'd3, 32'h0000_00AB}) begin
      bad++; $display("FAIL core_wr_rf got=%b/%h/%h exp=1/3/000000ab", rf_we, rf_addr, rf_wdata);
    end
    model[3] = 32'h0000_00AB;
    next_cycle();
    c_we = 0;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt, rf_we, rf_addr} !== {4'b0100, 4'd3}) begin
      bad++; $display("FAIL core_rd_gnt got=%b/%b/%h exp=010/0/3", {h_gnt, c_gnt, p_gnt}, rf_we, rf_addr);
    end
    push_read(1, 4'd3);
    next_cycle();
    idle();
    sample();
    total++;
    if ({c_rvalid, c_rdata} !== {1'b1, 32'h0000_00AB}) begin bad++; $display("FAIL core_rd_data got=%b/%h exp=1/000000ab", c_rvalid, c_rdata); end
    total++;
    if ({h_gnt, c_gnt, p_gnt, rf_we, rf_addr, rf_wdata} !== '0) begin
      bad++; $display("FAIL idle_bus got=%b/%b/%h/%h exp=0", {h_gnt, c_gnt, p_gnt}, rf_we, rf_addr, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    next_cycle();
    p_req = 1; p_we = 1; p_addr = 4'd2; p_wdata = 32'h2222_0002;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b001) begin bad++; $display("FAIL rr_prep_gnt got=%b exp=001", {h_gnt, c_gnt, p_gnt}); end
    model[2] = 32'h2222_0002;
    next_cycle();
    p_we = 0;
    c_req = 1; c_we = 0; c_addr = 4'd1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      sample();
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b001;
      total++;
      if ({h_gnt, c_gnt, p_gnt} !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, {h_gnt, c_gnt, p_gnt}, exp_g); end
      if (i > 0) begin
        total++;
        if ({c_rvalid, p_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_rvalid_lag[%0d] got=%b", i, {c_rvalid, p_rvalid});
        end
      end
      if (i % 2 == 0) push_read(1, 4'd1);
      else            push_read(2, 4'd2);
    end
    next_cycle();
    idle();
    sample();
  endtask

  task automatic test_host_priority();
    next_cycle();
    h_req = 1; h_we = 0; h_addr = 4'd5;
    c_req = 1; c_we = 0; c_addr = 4'd4;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      sample();
      total++;
      if ({h_gnt, c_gnt, p_gnt, starve_ovr} !== 4'b1000) begin
        bad++; $display("FAIL host_prio[%0d] got=%b exp=1000", i, {h_gnt, c_gnt, p_gnt, starve_ovr});
      end
      push_read(0, 4'd5);
    end
    next_cycle();
    h_req = 0;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b010) begin bad++; $display("FAIL host_release_gnt got=%b exp=010", {h_gnt, c_gnt, p_gnt}); end
    push_read(1, 4'd4);
    next_cycle();
    idle();
    sample();
  endtask

  task automatic test_host_dump();
    logic exp_c;
    next_cycle();
    h_req = 1; h_we = 0; h_addr = 4'd6;
    c_req = 1; c_we = 0; c_addr = 4'd7;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) next_cycle();
      sample();
      exp_c = (k == MAX_WAIT) || (k == 2 * MAX_WAIT + 1);
      total++;
      if ({h_gnt, c_gnt, p_gnt, starve_ovr} !== (exp_c ? 4'b0101 : 4'b1000)) begin
        bad++; $display("FAIL dump_cycle[%0d] got=%b exp=%b", k, {h_gnt, c_gnt, p_gnt, starve_ovr}, exp_c ? 4'b0101 : 4'b1000);
      end
      if (exp_c) push_read(1, 4'd7);
      else       push_read(0, 4'd6);
    end
    next_cycle();
    idle();
    sample();
  endtask

  task automatic test_lock();
    next_cycle();
    h_lock = 1;
    p_req = 1; p_we = 1; p_addr = 4'd8; p_wdata = 32'h5555_0008;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      if (k > 0) next_cycle();
      sample();
      total++;
      if (k < MAX_WAIT) begin
        if ({h_gnt, c_gnt, p_gnt, starve_ovr, rf_we} !== 5'b00000) begin
          bad++; $display("FAIL lock_block[%0d] got=%b exp=00000", k, {h_gnt, c_gnt, p_gnt, starve_ovr, rf_we});
        end
      end else begin
        if ({h_gnt, c_gnt, p_gnt, starve_ovr, rf_we, rf_addr} !== {5'b00111, 4'd8}) begin
          bad++; $display("FAIL lock_override got=%b/%h exp=00111/8", {h_gnt, c_gnt, p_gnt, starve_ovr, rf_we}, rf_addr);
        end
        model[8] = 32'h5555_0008;
      end
    end
    next_cycle();
    p_we = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      sample();
      total++;
      if ({h_gnt, c_gnt, p_gnt} !== 3'b000) begin bad++; $display("FAIL lock_hold[%0d] got=%b exp=000", k, {h_gnt, c_gnt, p_gnt}); end
    end
    next_cycle();
    h_lock = 0;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt, starve_ovr} !== 4'b0010) begin
      bad++; $display("FAIL unlock_gnt got=%b exp=0010", {h_gnt, c_gnt, p_gnt, starve_ovr});
    end
    push_read(2, 4'd8);
    next_cycle();
    idle();
    sample();
    total++;
    if ({p_rvalid, p_rdata} !== {1'b1, 32'h5555_0008}) begin bad++; $display("FAIL unlock_rdata got=%b/%h exp=1/55550008", p_rvalid, p_rdata); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    c_req = 1; c_we = 1; c_addr = 4'd9; c_wdata = 32'h9999_0001;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b010) begin bad++; $display("FAIL b2b_cwr got=%b exp=010", {h_gnt, c_gnt, p_gnt}); end
    model[9] = 32'h9999_0001;
    next_cycle();
    c_req = 0;
    p_req = 1; p_we = 0; p_addr = 4'd9;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt, rf_addr} !== {3'b001, 4'd9}) begin bad++; $display("FAIL b2b_prd got=%b/%h exp=001/9", {h_gnt, c_gnt, p_gnt}, rf_addr); end
    push_read(2, 4'd9);
    next_cycle();
    p_req = 0;
    h_req = 1; h_we = 1; h_addr = 4'd9; h_wdata = 32'hAAAA_0009;
    c_req = 1; c_we = 0; c_addr = 4'd9;
    sample();
    total++;
    if ({p_rvalid, p_rdata} !== {1'b1, 32'h9999_0001}) begin bad++; $display("FAIL b2b_p_rdata got=%b/%h exp=1/99990001", p_rvalid, p_rdata); end
    total++;
    if ({h_gnt, c_gnt, p_gnt, rf_we} !== 4'b1001) begin bad++; $display("FAIL b2b_hwr got=%b exp=1001", {h_gnt, c_gnt, p_gnt, rf_we}); end
    model[9] = 32'hAAAA_0009;
    next_cycle();
    h_req = 0;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b010) begin bad++; $display("FAIL b2b_crd got=%b exp=010", {h_gnt, c_gnt, p_gnt}); end
    push_read(1, 4'd9);
    next_cycle();
    idle();
    sample();
    total++;
    if (c_rdata !== 32'hAAAA_0009) begin bad++; $display("FAIL b2b_c_rdata got=%h exp=aaaa0009", c_rdata); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    c_req = 1; c_we = 0; c_addr = 4'd1;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b010) begin bad++; $display("FAIL rstmid_pre got=%b exp=010", {h_gnt, c_gnt, p_gnt}); end
    push_read(1, 4'd1);
    next_cycle();
    c_req = 0;
    p_req = 1; p_we = 0; p_addr = 4'd2;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b001) begin bad++; $display("FAIL rstmid_pgnt got=%b exp=001", {h_gnt, c_gnt, p_gnt}); end
    rst = 1;
    #1;
    c_req = 1; c_we = 1; c_addr = 4'd1; c_wdata = 32'hBAD0_0001;
    #1;
    total++;
    if ({h_gnt, c_gnt, p_gnt, rf_we} !== 4'b0000) begin bad++; $display("FAIL rstmid_nowrite got=%b exp=0000", {h_gnt, c_gnt, p_gnt, rf_we}); end
    next_cycle();
    sample();
    total++;
    if ({p_rvalid, c_rvalid, h_rvalid} !== 3'b000) begin bad++; $display("FAIL rstmid_rvalid got=%b exp=000", {p_rvalid, c_rvalid, h_rvalid}); end
    total++;
    if ({h_rdata, c_rdata, p_rdata} !== '0) begin bad++; $display("FAIL rstmid_rdata got=%h/%h/%h exp=0", h_rdata, c_rdata, p_rdata); end
    next_cycle();
    rst = 0;
    c_we = 0;
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt, starve_ovr} !== 4'b0100) begin bad++; $display("FAIL rstmid_tie got=%b exp=0100", {h_gnt, c_gnt, p_gnt, starve_ovr}); end
    push_read(1, 4'd1);
    next_cycle();
    sample();
    total++;
    if ({h_gnt, c_gnt, p_gnt} !== 3'b001) begin bad++; $display("FAIL rstmid_next got=%b exp=001", {h_gnt, c_gnt, p_gnt}); end
    push_read(2, 4'd2);
    next_cycle();
    idle();
    sample();
  endtask

  initial begin
    rst = 1;
    idle();
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 32'hC0DE_0000 | i;
      model[i] = 32'hC0DE_0000 | i;
    end
    test_reset();
    test_core_only();
    test_round_robin();
    test_host_priority();
    test_host_dump();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    repeat (3) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
